// File: rtl/uart_alu_sequencer.sv
// Frame controller between UART RX/TX and a combinational ALU.
// Collects A, B, opcode; sends the registered result; aborts stale frames.
module uart_alu_sequencer #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6,
  parameter int TMO   = 4800,
  parameter int TW    = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             rx_done_tick,
  input  logic [DBIT-1:0]  rx_data,
  input  logic             tx_done_tick,
  input  logic [DBIT-1:0]  alu_result,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  output logic             tx_start,
  output logic [DBIT-1:0]  tx_data,
  output logic             busy,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_CALC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t        state;
  logic [TW-1:0] cnt;
  logic          tmo_hit;

  assign tmo_hit = s_tick && (cnt == TW'(TMO - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_WAIT_A;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_WAIT_A: begin
          if (rx_done_tick) begin
            alu_a <= rx_data;
            cnt   <= '0;
            state <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          // an arriving byte always wins over an expiring tick
          if (rx_done_tick) begin
            alu_b <= rx_data;
            cnt   <= '0;
            state <= S_WAIT_OP;
          end else if (tmo_hit) begin
            cnt     <= '0;
            timeout <= 1'b1;
            state   <= S_WAIT_A;
          end else if (s_tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_OP: begin
          if (rx_done_tick) begin
            alu_op <= rx_data[NB_OP-1:0];
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end else if (tmo_hit) begin
            cnt     <= '0;
            timeout <= 1'b1;
            state   <= S_WAIT_A;
          end else if (s_tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CALC: begin
          tx_data  <= alu_result;
          tx_start <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          state <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_done_tick) begin
            busy  <= 1'b0;
            state <= S_WAIT_A;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_WAIT_A;
        end
      endcase
      if (rx_done_tick && busy)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer: frame table plus
// timeout, overrun, reset-mid-TX and back-to-back sequences.
module tb_uart_alu_sequencer;

  localparam int DBIT  = 8;
  localparam int NB_OP = 6;
  localparam int TMO   = 20;
  localparam int TW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_tick = 1'b0;
  logic             rx_done_tick = 1'b0;
  logic [DBIT-1:0]  rx_data = '0;
  logic             tx_done_tick = 1'b0;
  logic [DBIT-1:0]  alu_result;
  logic [DBIT-1:0]  alu_a;
  logic [DBIT-1:0]  alu_b;
  logic [NB_OP-1:0] alu_op;
  logic             tx_start;
  logic [DBIT-1:0]  tx_data;
  logic             busy;
  logic             timeout;
  logic             overrun;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_tmo = 0;
  int exp_start = 0;
  int exp_tmo = 0;

  always #5 clk = ~clk;

  uart_alu_sequencer #(
    .DBIT(DBIT), .NB_OP(NB_OP), .TMO(TMO), .TW(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_tick(s_tick),
    .rx_done_tick(rx_done_tick),
    .rx_data(rx_data),
    .tx_done_tick(tx_done_tick),
    .alu_result(alu_result),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .busy(busy),
    .timeout(timeout),
    .overrun(overrun)
  );

  // ALU environment model
  always_comb begin
    alu_result = '0;
    case (alu_op)
      6'h20: alu_result = alu_a + alu_b;
      6'h22: alu_result = alu_a - alu_b;
      6'h24: alu_result = alu_a & alu_b;
      6'h25: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  always @(negedge clk) begin
    if (tx_start) n_start++;
    if (timeout) n_tmo++;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic do_tick();
    s_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    send_byte(v.a);
    send_byte(v.b);
    send_byte(v.op);
    check("calc_start", 32'(tx_start), 0);
    check("calc_busy", 32'(busy), 1);
    check("alu_a", 32'(alu_a), 32'(v.a));
    check("alu_b", 32'(alu_b), 32'(v.b));
    check("alu_op", 32'(alu_op), 32'(v.exp_op));
    @(negedge clk);
    exp_start++;
    check("tx_start", 32'(tx_start), 1);
    check("tx_data", 32'(tx_data), 32'(v.exp_res));
    @(negedge clk);
    check("start_pulse", 32'(tx_start), 0);
    check("wait_busy", 32'(busy), 1);
    pulse_tx_done();
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vecs[1] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
    vecs[2] = '{8'h0A, 8'h04, 8'h22, 6'h22, 8'h06};
    vecs[3] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
    vecs[4] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
    vecs[5] = '{8'h12, 8'h34, 8'hE0, 6'h20, 8'h46};
    vecs[6] = '{8'h07, 8'h09, 8'h3F, 6'h3F, 8'h00};

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_alu", {alu_a, alu_b, 2'b00, alu_op, 8'h00}, 0);
    check("rst_flags", {busy, timeout, overrun}, 0);
    reset = 1'b0;
    @(negedge clk);

    // T1/T6: back-to-back frames, tx_done one cycle after tx_start
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);
    check("no_overrun", 32'(overrun), 0);

    // T2: timeout after a single byte
    send_byte(8'h05);
    for (int i = 0; i < TMO - 1; i++) do_tick();
    check("tmo_early", 32'(timeout), 0);
    do_tick();
    exp_tmo++;
    check("tmo_pulse", 32'(timeout), 1);
    @(negedge clk);
    check("tmo_one_clk", 32'(timeout), 0);
    check("tmo_keep_a", 32'(alu_a), 32'h05);
    v = '{8'h07, 8'h02, 8'h22, 6'h22, 8'h05};
    run_frame(v);

    // timeout also runs in WAIT_OP
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 0; i < TMO; i++) do_tick();
    exp_tmo++;
    check("tmo_op_pulse", 32'(timeout), 1);
    check("tmo_op_busy", 32'(busy), 0);

    // T3: opcode coincident with expiring tick
    send_byte(8'h05);
    send_byte(8'h03);
    for (int i = 0; i < TMO - 1; i++) do_tick();
    s_tick = 1'b1;
    send_byte(8'h24);
    s_tick = 1'b0;
    check("coinc_no_tmo", 32'(timeout), 0);
    check("coinc_busy", 32'(busy), 1);
    @(negedge clk);
    exp_start++;
    check("coinc_start", 32'(tx_start), 1);
    check("coinc_data", 32'(tx_data), 32'h01);
    @(negedge clk);
    pulse_tx_done();

    // T4: byte during WAIT_TX is dropped and flags overrun
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h25);
    @(negedge clk);
    exp_start++;
    check("ovr_start", 32'(tx_start), 1);
    send_byte(8'h99);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_data", 32'(tx_data), 32'h11);
    check("ovr_a", 32'(alu_a), 32'h10);
    check("ovr_busy", 32'(busy), 1);
    pulse_tx_done();
    v = '{8'h03, 8'h04, 8'h20, 6'h20, 8'h07};
    run_frame(v);
    check("ovr_sticky", 32'(overrun), 1);

    // T5: reset between tx_start and tx_done
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h20);
    @(negedge clk);
    exp_start++;
    check("rst5_start", 32'(tx_start), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst5_tx_data", 32'(tx_data), 0);
    check("rst5_alu", {alu_a, alu_b, 2'b00, alu_op, 8'h00}, 0);
    check("rst5_flags", {tx_start, busy, timeout, overrun}, 0);
    pulse_tx_done();
    @(negedge clk);
    check("rst5_ign_done", {tx_start, busy}, 0);
    v = '{8'h0A, 8'h04, 8'h22, 6'h22, 8'h06};
    run_frame(v);

    check("start_count", 32'(n_start), 32'(exp_start));
    check("tmo_count", 32'(n_tmo), 32'(exp_tmo));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
